// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store buffer datapath/memory bus bundle
// Purpose: groups the store, load, fence and DataMemory signals of store_buffer.
// Ports (modports):
//   slave  - the store buffer: takes st_*/ld_*/fence/mem_rdata, drives st_ready, ld_ready,
//            ld_data, fence_done, mem_address, mem_wdata, mem_read, mem_write, count
//   master - the datapath plus DataMemory side, the mirror image of slave
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              fence;
  logic              fence_done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, fence, mem_rdata,
    output st_ready, ld_ready, ld_data, fence_done, mem_address, mem_wdata,
           mem_read, mem_write, count
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, fence, mem_rdata,
    input  st_ready, ld_ready, ld_data, fence_done, mem_address, mem_wdata,
           mem_read, mem_write, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO in front of single-ported DataMemory with load forwarding
// Purpose: queues stores, drains them when no load needs the memory port, forwards pending
//          store data to matching loads and supports a draining fence.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - store_buffer_if.slave: store/load/fence requests and DataMemory port
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, FENCE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_miss;
  logic [PTR_W-1:0]  idx;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Only registered state plus the fence request gate acceptance; the pop never feeds back.
  assign bus.st_ready   = (state == RUN) && !bus.fence && !full;
  assign push           = bus.st_valid && bus.st_ready;
  assign bus.fence_done = (state == FENCE) && bus.fence && empty;
  assign bus.count      = count_q;

  // Walk oldest to youngest so the last match wins; this deliberately includes the
  // head entry even if it is popping this cycle, and never sees this cycle's push.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (bus.ld_valid && (CNT_W'(i) < count_q) && (addr_mem[idx] == bus.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  assign ld_miss = bus.ld_valid && !fwd_hit;

  // Memory port arbitration: a full buffer must drain (a missing load retries),
  // otherwise loads beat background drains.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.ld_ready    = 1'b0;
    bus.ld_data     = '0;
    if (full) begin
      bus.mem_write   = 1'b1;
      bus.mem_address = addr_mem[head];
      bus.mem_wdata   = data_mem[head];
    end else if (ld_miss) begin
      bus.mem_read    = 1'b1;
      bus.mem_address = bus.ld_addr;
      bus.ld_ready    = 1'b1;
      bus.ld_data     = bus.mem_rdata;
    end else if (!empty) begin
      bus.mem_write   = 1'b1;
      bus.mem_address = addr_mem[head];
      bus.mem_wdata   = data_mem[head];
    end
    if (fwd_hit) begin
      bus.ld_ready = 1'b1;
      bus.ld_data  = fwd_data;
    end
  end

  assign pop = bus.mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      case (state)
        RUN:     if (bus.fence)  state <= FENCE;
        FENCE:   if (!bus.fence) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.st_addr;
      data_mem[tail] <= bus.st_data;
    end
  end
endmodule
